intc: RTL and testbench
=======================

# intc

Interrupt controller for the comproc CPU: collects up to 15 external interrupt sources, latches them as pending, masks and prioritises them, and drives the single `irq` input of the CPU control unit. Software configures it and acknowledges interrupts through a small 16-bit memory-mapped register window. The CPU's interrupt entry is reported back via `irq_ack`. The block holds one interrupt in service, and no further `irq` is raised until software writes end-of-interrupt (EOI).

## Interface
Parameters:
- `NSRC`, 8: number of sources, 1..15. Source 0 has the highest priority.

Ports (reset `rst` is asynchronous, active-high; clock is `clk`):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `src`  in  NSRC  raw interrupt request lines
- `irq`  out  1  interrupt request to the CPU control unit
- `irq_ack`  in  1  one-cycle pulse, high in the cycle the CPU begins interrupt entry
- `addr`  in  2  register select: word index 0..3
- `wr`  in  1  register write strobe
- `rd`  in  1  register read strobe
- `wdata`  in  16  write data
- `rdata`  out  16  read data, registered

## Operation
- Source stage: `s[i]` is `src[i]`, or its synchronised copy (see Configuration). `s_q` is `s` delayed one clock.
- Per-source mode is set by `EDGE[i]`:
  - 1 = rising-edge mode: `pend[i]` sets on `s[i] & ~s_q[i]`.
  - 0 = level mode: `pend[i]` follows `s[i]` every cycle and is not software-clearable.
- Request: `req = pend & MASK`. `irq = |req & ~in_service`. `irq` is combinational from registers.
- Acknowledge (`irq_ack`=1):
  - `in_service` is set to 1.
  - `cause_id` is set to the lowest index i with `req[i]`=1.
  - If that source is in edge mode, its `pend` bit is cleared.
  - If `req`=0 at ack (spurious ack), `cause_id` is set to 15 and no pend bit changes.
- Register map (reads at word index; result on `rdata` the cycle after `rd`):
  - 0 PEND: read returns pend. A write clears, for each `wdata` bit set to 1, the corresponding pend bit if that source is in edge mode (write-1-to-clear).
  - 1 MASK: read/write. 1 = enabled.
  - 2 EDGE: read/write. 1 = edge mode.
  - 3 CAUSE: read returns `{in_service, 11'b0, cause_id[3:0]}`. Any write is EOI and clears `in_service`; `cause_id` is kept.
- Bits at or above `NSRC` read as 0 and ignore writes.
- Simultaneous events:
  - An edge event and a W1C write on the same bit in the same cycle: set wins.
  - An edge event and an ack-clear on the same bit in the same cycle: set wins, so pend stays 1.
  - `irq_ack` and an EOI write in the same cycle: ack wins, so `in_service` ends at 1.
  - `rd` and `wr` to the same register in the same cycle: `rdata` returns the pre-write value.
  - Changing EDGE on a bit clears that bit's pend in the same cycle. In the new mode, pend resumes normal behaviour from the next cycle.

## Timing
- Reset values: `pend`=0, `MASK`=0, `EDGE`=0, `in_service`=0, `cause_id`=0, `s_q`=0, synchroniser flops=0, `irq`=0, `rdata`=0. Reset asserted mid-operation clears all of these immediately, without waiting for a clock.
- Latency from a `src` rise (sampled at clock edge k) to `irq` high:
  - Without sync: high after edge k, i.e. 1 cycle (`pend` registers at edge k).
  - With sync: 3 cycles.
- `irq_ack` at edge k: `irq` is low after edge k. `CAUSE` reflects the new id when read with `rd` at edge k+1.
- EOI at edge k with `req`≠0: `irq` is high after edge k.
- Register reads: `rdata` is valid one cycle after `rd` and holds until the next `rd`.
- The CPU samples `irq` only in its fetch phase. The block places no further constraint on that sampling.

## Configuration
- `INTC_SYNC_EN`:
  - Defined: each `src` bit passes through a two-flop synchroniser before `s`, which adds 2 cycles of latency.
  - Undefined: `s = src` directly, and `src` must be synchronous to `clk`.

## Test plan
- Reset, then write MASK=0x0003 and EDGE=0x0001, then pulse `src[0]` for 1 cycle -> `irq`=1 (after 1 cycle, or 3 with sync). Then `irq_ack` -> `irq`=0 and CAUSE reads 0x8000. Then EOI -> CAUSE reads 0x0000.
- Hold `src[1]` and `src[0]` high (both level mode, both masked in) -> ack gives id 0. After EOI with `src[0]` dropped -> `irq` reasserts, and the next ack gives CAUSE 0x8001.
- Edge source 2 masked out (MASK=0x0000), pulse `src[2]` -> PEND reads 0x0004 and `irq`=0. Write MASK=0x0004 -> `irq`=1. Write PEND=0x0004 -> PEND reads 0 and `irq`=0.
- Edge on `src[0]` in the same cycle as a W1C of bit 0 -> PEND bit 0 remains 1. Edge in the same cycle as `irq_ack` for source 0 -> PEND bit 0 remains 1, and `irq` reasserts after EOI.
- `irq_ack` with `req`=0 -> CAUSE reads 0x800F and PEND is unchanged.
- Assert `rst` while `in_service`=1 and PEND=0x0003 -> all registers read 0 and `irq`=0 before the next clock edge.

Source files
------------

// File: rtl/intc.sv
// intc: interrupt controller; latches, masks and prioritises NSRC sources onto one irq with a 4-word register window.
// Ports: clk, rst (async, active-high); src[NSRC] raw requests; irq to CPU; irq_ack CPU entry pulse;
//        addr/wr/rd/wdata/rdata 16-bit register window (0 PEND w1c, 1 MASK, 2 EDGE, 3 CAUSE / EOI on write).
// Optional INTC_SYNC_EN: two-flop synchroniser on every src bit.
module intc #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  input  logic            irq_ack,
  input  logic [1:0]      addr,
  input  logic            wr,
  input  logic            rd,
  input  logic [15:0]     wdata,
  output logic [15:0]     rdata
);
  logic [NSRC-1:0] s, s_q, pend, pend_n, mask, edge_r, req, set, w1c, ack_clr, edge_chg;
  logic in_service;
  logic [3:0] cause_id, id;
  logic [15:0] rd_val;
`ifdef INTC_SYNC_EN
  logic [NSRC-1:0] sync1, sync2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  assign s = sync2;
`else
  assign s = src;
`endif
  assign req      = pend & mask;
  assign irq      = |req & ~in_service;
  assign set      = s & ~s_q & edge_r;
  assign w1c      = (wr && addr == 2'd0) ? wdata[NSRC-1:0] : '0;
  assign edge_chg = (wr && addr == 2'd2) ? (wdata[NSRC-1:0] ^ edge_r) : '0;
  // lowest requesting index wins; 15 marks a spurious ack
  always_comb begin
    id = 4'd15;
    for (int i = NSRC - 1; i >= 0; i--)
      if (req[i]) id = 4'(i);
    for (int i = 0; i < NSRC; i++)
      ack_clr[i] = irq_ack && id == 4'(i);
  end
  // edge set beats any clear; a mode change clears the bit for one cycle
  assign pend_n = ~edge_chg & ((edge_r & (set | (pend & ~(w1c | ack_clr)))) | (~edge_r & s));
  assign rd_val = addr == 2'd0 ? 16'(pend) :
                  addr == 2'd1 ? 16'(mask) :
                  addr == 2'd2 ? 16'(edge_r) : {in_service, 11'b0, cause_id};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_q        <= '0;
      pend       <= '0;
      mask       <= '0;
      edge_r     <= '0;
      in_service <= 1'b0;
      cause_id   <= 4'd0;
      rdata      <= 16'd0;
    end else begin
      s_q  <= s;
      pend <= pend_n;
      if (wr && addr == 2'd1) mask <= wdata[NSRC-1:0];
      if (wr && addr == 2'd2) edge_r <= wdata[NSRC-1:0];
      if (irq_ack) begin
        in_service <= 1'b1;
        cause_id   <= id;
      end else if (wr && addr == 2'd3) in_service <= 1'b0;
      if (rd) rdata <= rd_val;
    end
endmodule

// File: tb/tb_intc.sv
// tb_intc: randomized and directed self-checking bench for intc against a rule-level model.
module tb_intc;
  localparam int N = 8;
`ifdef INTC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst = 1, irq_ack = 0, wr = 0, rd = 0;
  logic [N-1:0] src = '0;
  logic [1:0] addr = '0;
  logic [15:0] wdata = '0;
  logic irq;
  logic [15:0] rdata;
  int passed = 0, total = 0;

  intc #(.NSRC(N)) dut (.clk(clk), .rst(rst), .src(src), .irq(irq), .irq_ack(irq_ack),
                        .addr(addr), .wr(wr), .rd(rd), .wdata(wdata), .rdata(rdata));

  always #5 clk = ~clk;

  logic [N-1:0] m_pend, m_mask, m_edge, m_sq, m_y1, m_y2;
  bit m_isv;
  int m_cause;
  logic [15:0] m_rdata;

  task automatic m_reset();
    m_pend = '0; m_mask = '0; m_edge = '0; m_sq = '0; m_y1 = '0; m_y2 = '0;
    m_isv = 0; m_cause = 0; m_rdata = '0;
  endtask

  function automatic bit m_irq();
    bit any = 0;
    for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) any = 1;
    return any && !m_isv;
  endfunction

  function automatic logic [15:0] m_reg(input logic [1:0] a);
    if (a == 0) return 16'(m_pend);
    if (a == 1) return 16'(m_mask);
    if (a == 2) return 16'(m_edge);
    return {m_isv, 11'b0, 4'(m_cause)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    check("irq", {15'b0, irq}, {15'b0, m_irq()});
    check("rdata", rdata, m_rdata);
  end

  task automatic tick();
    logic [N-1:0] s_now, np;
    logic [15:0] nr;
    int id;
`ifdef INTC_SYNC_EN
    s_now = m_y2;
`else
    s_now = src;
`endif
    id = 15;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) id = i;
    for (int i = 0; i < N; i++) begin
      if (wr && addr == 2 && wdata[i] != m_edge[i]) np[i] = 0;
      else if (!m_edge[i]) np[i] = s_now[i];
      else if (s_now[i] && !m_sq[i]) np[i] = 1;
      else if ((wr && addr == 0 && wdata[i]) || (irq_ack && id == i)) np[i] = 0;
      else np[i] = m_pend[i];
    end
    nr = rd ? m_reg(addr) : m_rdata;
    @(posedge clk);
    #1;
    if (rst) m_reset();
    else begin
      m_pend = np;
      if (wr && addr == 1) m_mask = wdata[N-1:0];
      if (wr && addr == 2) m_edge = wdata[N-1:0];
      if (irq_ack) begin
        m_isv = 1;
        m_cause = id;
      end else if (wr && addr == 3) m_isv = 0;
      m_rdata = nr;
      m_sq = s_now;
      m_y2 = m_y1;
      m_y1 = src;
    end
  endtask

  task automatic cyc(input logic [N-1:0] sv, input bit ack, input bit w, input bit r,
                     input logic [1:0] a, input logic [15:0] d);
    src = sv; irq_ack = ack; wr = w; rd = r; addr = a; wdata = d;
    tick();
    irq_ack = 0; wr = 0; rd = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(src, 0, 0, 0, 0, 0);
  endtask

  task automatic wreg(input logic [1:0] a, input logic [15:0] d);
    cyc(src, 0, 1, 0, a, d);
  endtask

  task automatic rreg(input logic [1:0] a);
    cyc(src, 0, 0, 1, a, 0);
  endtask

  // raise src[0] so its edge reaches the pend logic in the same cycle as the given strobe
  task automatic rise_with(input bit ack, input bit w, input logic [1:0] a, input logic [15:0] d);
    for (int i = 0; i < LAT - 1; i++) cyc(src | 1, 0, 0, 0, 0, 0);
    cyc(src | 1, ack, w, 0, a, d);
  endtask

  initial begin
    m_reset();
    idle(3);
    rst = 0;
    idle(1);
    check("reset_irq", {15'b0, irq}, 16'h0);
    check("reset_rdata", rdata, 16'h0);
    // edge source 0 through ack and EOI
    wreg(1, 16'h0003);
    wreg(2, 16'h0001);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < LAT - 2; i++) idle(1);
    check("edge_irq", {15'b0, irq}, 16'h1);
    cyc(0, 1, 0, 0, 0, 0);
    check("ack_irq_low", {15'b0, irq}, 16'h0);
    rreg(3);
    check("cause_0", rdata, 16'h8000);
    wreg(3, 0);
    rreg(3);
    check("cause_eoi", rdata, 16'h0000);
    // two level sources, priority then re-assertion
    wreg(2, 0);
    cyc(3, 0, 0, 0, 0, 0);
    idle(LAT);
    cyc(src, 1, 0, 0, 0, 0);
    rreg(3);
    check("cause_prio", rdata, 16'h8000);
    cyc(2, 0, 0, 0, 0, 0);
    idle(LAT + 1);
    wreg(3, 0);
    check("eoi_reassert", {15'b0, irq}, 16'h1);
    cyc(src, 1, 0, 0, 0, 0);
    rreg(3);
    check("cause_1", rdata, 16'h8001);
    cyc(0, 0, 0, 0, 0, 0);
    wreg(3, 0);
    idle(LAT + 1);
    // masked edge source 2, unmask, then W1C
    wreg(1, 0);
    wreg(2, 16'h0004);
    cyc(4, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    idle(LAT);
    rreg(0);
    check("pend_masked", rdata, 16'h0004);
    check("masked_irq", {15'b0, irq}, 16'h0);
    wreg(1, 16'h0004);
    check("unmask_irq", {15'b0, irq}, 16'h1);
    wreg(0, 16'h0004);
    check("w1c_irq", {15'b0, irq}, 16'h0);
    rreg(0);
    check("pend_w1c", rdata, 16'h0000);
    // edge vs W1C, edge vs ack
    wreg(1, 16'h0001);
    wreg(2, 16'h0001);
    rise_with(0, 1, 0, 16'h0001);
    cyc(0, 0, 0, 0, 0, 0);
    rreg(0);
    check("set_beats_w1c", rdata, 16'h0001);
    rise_with(1, 0, 0, 0);
    check("ack_edge_irq", {15'b0, irq}, 16'h0);
    cyc(0, 0, 0, 0, 0, 0);
    rreg(0);
    check("set_beats_ack", rdata, 16'h0001);
    wreg(3, 0);
    check("eoi_after_ack_edge", {15'b0, irq}, 16'h1);
    cyc(0, 1, 0, 0, 0, 0);
    wreg(3, 0);
    check("cleared_irq", {15'b0, irq}, 16'h0);
    // spurious ack
    wreg(1, 0);
    wreg(2, 0);
    cyc(2, 0, 0, 0, 0, 0);
    idle(LAT);
    cyc(src, 1, 0, 0, 0, 0);
    rreg(3);
    check("cause_spurious", rdata, 16'h800F);
    rreg(0);
    check("pend_spurious", rdata, 16'h0002);
    wreg(3, 0);
    // async reset while in service
    wreg(1, 16'h0003);
    cyc(3, 0, 0, 0, 0, 0);
    idle(LAT);
    cyc(src, 1, 0, 0, 0, 0);
    rreg(0);
    check("pend_before_rst", rdata, 16'h0003);
    #2;
    rst = 1;
    m_reset();
    #1;
    check("async_rst_irq", {15'b0, irq}, 16'h0);
    check("async_rst_rdata", rdata, 16'h0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst = 0;
    for (int a = 0; a < 4; a++) begin
      rreg(2'(a));
      check("post_rst_reg", rdata, 16'h0);
    end
    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] ns;
      ns = src ^ (N'($urandom) & N'($urandom) & N'($urandom));
      cyc(ns, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
          2'($urandom), 16'($urandom));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
